// File: rtl/spi_pwm_pkg.sv
// Shared constants, register map and FSM state type for the SPI control slave
// that feeds the 3-channel PWM.
package spi_pwm_pkg;

  localparam int FRAME_BITS = 40;
  localparam int CMD_BITS   = 8;

  localparam logic [31:0] ID_VALUE = 32'h5057_4D31;

  localparam logic [6:0] ADDR_DUTY = 7'h00;
  localparam logic [6:0] ADDR_FREQ = 7'h01;
  localparam logic [6:0] ADDR_CTRL = 7'h02;
  localparam logic [6:0] ADDR_ID   = 7'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WAIT
  } spi_state_e;

  // Read-back view of the register file; unmapped addresses read as zero.
  function automatic logic [31:0] reg_read_value(input logic [6:0]  addr,
                                                 input logic [23:0] duty,
                                                 input logic [31:0] freq,
                                                 input logic        en);
    logic [31:0] value;
    case (addr)
      ADDR_DUTY: value = {8'h00, duty};
      ADDR_FREQ: value = freq;
      ADDR_CTRL: value = {31'd0, en};
      ADDR_ID:   value = ID_VALUE;
      default:   value = 32'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, with rise/fall detection
// against a one-cycle delayed copy of the synchronised level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      dly_q  <= RESET_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~dly_q;
  assign fall     = ~sync_q & dly_q;

endmodule

// File: rtl/spi_pwm_regs.sv
// SPI mode-0 slave oversampled in the clk domain, decoding 40-bit frames into
// the PWM control registers (duty, frequency, enable) with full read-back.
module spi_pwm_regs
  import spi_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [23:0] duty_cycle,
  output logic [31:0] frequency,
  output logic        enable,
  output logic        frame_valid,
  output logic        frame_error
);

  localparam logic [5:0] CMD_LAST   = 6'(CMD_BITS - 1);
  localparam logic [5:0] CMD_COUNT  = 6'(CMD_BITS);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_lvl_unused;
  logic cs_rise;
  logic cs_fall;
  logic mosi_s;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .reset    (reset),
    .async_in (sclk),
    .sync_out (sclk_lvl_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // Chip select idles high, so its synchroniser resets high to avoid a
  // phantom falling edge when reset is released with cs_n deasserted.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk      (clk),
    .reset    (reset),
    .async_in (cs_n),
    .sync_out (cs_lvl_unused),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk      (clk),
    .reset    (reset),
    .async_in (mosi),
    .sync_out (mosi_s),
    .rise     (mosi_rise_unused),
    .fall     (mosi_fall_unused)
  );

  spi_state_e  state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [31:0] rx_q,    rx_d;
  logic [7:0]  cmd_q,   cmd_d;
  logic [31:0] tx_q,    tx_d;
  logic [23:0] duty_q,  duty_d;
  logic [31:0] freq_q,  freq_d;
  logic        en_q,    en_d;
  logic        miso_q,  miso_d;
  logic        fv_q,    fv_d;
  logic        fe_q,    fe_d;

  logic [31:0] rx_shift;
  assign rx_shift = {rx_q[30:0], mosi_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    cmd_d   = cmd_q;
    tx_d    = tx_q;
    duty_d  = duty_q;
    freq_d  = freq_q;
    en_d    = en_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_CMD;
          cnt_d   = 6'd0;
          rx_d    = 32'd0;
        end
      end

      ST_CMD: begin
        if (cs_rise) begin
          fe_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == CMD_LAST) begin
            cmd_d   = rx_shift[7:0];
            tx_d    = rx_shift[7] ? 32'd0
                                  : reg_read_value(rx_shift[6:0], duty_q, freq_q, en_q);
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (cs_rise) begin
          fe_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (sclk_rise) begin
            rx_d  = rx_shift;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == FRAME_LAST) begin
              fv_d    = 1'b1;
              state_d = ST_WAIT;
              if (cmd_q[7]) begin
                case (cmd_q[6:0])
                  ADDR_DUTY: duty_d = rx_shift[23:0];
                  ADDR_FREQ: freq_d = rx_shift;
                  ADDR_CTRL: en_d   = rx_shift[0];
                  default:   ;
                endcase
              end
            end
          end
          // The fall right after the 8th rise must keep tx[31] on the pin:
          // the host samples the first data bit on the 9th rise.
          if (sclk_fall && (cnt_q > CMD_COUNT)) begin
            tx_d = {tx_q[30:0], 1'b0};
          end
        end
      end

      ST_WAIT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (cs_fall) begin
          state_d = ST_CMD;
          cnt_d   = 6'd0;
          rx_d    = 32'd0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    miso_d = ((state_d == ST_DATA) && !cmd_d[7]) ? tx_d[31] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      rx_q    <= 32'd0;
      cmd_q   <= 8'd0;
      tx_q    <= 32'd0;
      duty_q  <= 24'd0;
      freq_q  <= 32'd0;
      en_q    <= 1'b0;
      miso_q  <= 1'b0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      cmd_q   <= cmd_d;
      tx_q    <= tx_d;
      duty_q  <= duty_d;
      freq_q  <= freq_d;
      en_q    <= en_d;
      miso_q  <= miso_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  assign miso        = miso_q;
  assign duty_cycle  = duty_q;
  assign frequency   = freq_q;
  assign enable      = en_q;
  assign frame_valid = fv_q;
  assign frame_error = fe_q;

endmodule

// File: tb/tb_spi_pwm_regs.sv
// Self-checking bench for spi_pwm_regs: directed and randomised SPI frames
// checked cycle by cycle against a register-level model of the slave.
module tb_spi_pwm_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [23:0] duty_cycle;
  logic [31:0] frequency;
  logic        enable;
  logic        frame_valid;
  logic        frame_error;

  spi_pwm_regs dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .duty_cycle  (duty_cycle),
    .frequency   (frequency),
    .enable      (enable),
    .frame_valid (frame_valid),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Register-level model of what the PWM should currently see.
  logic [23:0] mdl_duty = '0;
  logic [31:0] mdl_freq = '0;
  logic        mdl_en   = 1'b0;
  logic        exp_fv   = 1'b0;
  logic        exp_fe   = 1'b0;
  int          fv_cnt   = 0;
  int          fe_cnt   = 0;
  logic        pend_w   = 1'b0;
  logic [6:0]  pend_addr = '0;
  logic [31:0] pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [6:0] addr);
    if (addr == 7'h00) return {8'h00, mdl_duty};
    if (addr == 7'h01) return mdl_freq;
    if (addr == 7'h02) return {31'd0, mdl_en};
    if (addr == 7'h03) return 32'h5057_4D31;
    return 32'd0;
  endfunction

  // Outcomes land on the 3rd clk rise after the pad change was first sampled.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_duty = '0;
      mdl_freq = '0;
      mdl_en   = 1'b0;
      exp_fv   = 1'b0;
      exp_fe   = 1'b0;
      fv_cnt   = 0;
      fe_cnt   = 0;
    end else begin
      exp_fv = 1'b0;
      exp_fe = 1'b0;
      if (fv_cnt > 0) begin
        fv_cnt--;
        if (fv_cnt == 0) begin
          exp_fv = 1'b1;
          if (pend_w) begin
            if (pend_addr == 7'h00) mdl_duty = pend_data[23:0];
            if (pend_addr == 7'h01) mdl_freq = pend_data;
            if (pend_addr == 7'h02) mdl_en   = pend_data[0];
          end
        end
      end
      if (fe_cnt > 0) begin
        fe_cnt--;
        if (fe_cnt == 0) exp_fe = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("duty_cycle",  32'(duty_cycle),  32'(mdl_duty));
    check("frequency",   frequency,        mdl_freq);
    check("enable",      32'(enable),      32'(mdl_en));
    check("frame_valid", 32'(frame_valid), 32'(exp_fv));
    check("frame_error", 32'(frame_error), 32'(exp_fe));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI transaction of nbits sclk pulses; do_reset aborts it with reset
  // asserted after 20 bits (inside the data phase).
  task automatic spi_frame(input logic w, input logic [6:0] addr, input logic [31:0] data,
                           input int nbits, input bit do_reset, output logic [31:0] rd);
    logic [39:0] frame;
    int h;
    frame = {w, addr, data};
    rd = '0;
    h = $urandom_range(6, 4);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 40) ? frame[39 - i] : 1'($urandom_range(1, 0));
      tick(h);
      if (i >= 8 && i < 40) begin
        if (w) check("miso_write", 32'(miso), 32'd0);
        else   rd[39 - i] = miso;
      end
      if (do_reset && i == 20) begin
        reset = 1'b1;
        #1;
        check("rst_duty",  32'(duty_cycle),  32'd0);
        check("rst_freq",  frequency,        32'd0);
        check("rst_en",    32'(enable),      32'd0);
        check("rst_miso",  32'(miso),        32'd0);
        check("rst_fv",    32'(frame_valid), 32'd0);
        check("rst_fe",    32'(frame_error), 32'd0);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(6);
        return;
      end
      sclk = 1'b1;
      if (i == 39) begin
        pend_w    = w;
        pend_addr = addr;
        pend_data = data;
        fv_cnt    = 3;
      end
      tick(h);
      sclk = 1'b0;
    end
    tick(h);
    cs_n = 1'b1;
    if (nbits < 40) fe_cnt = 3;
    mosi = 1'b0;
    tick(8);
    check("miso_idle", 32'(miso), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;
    logic        w;
    logic [6:0]  addr;
    logic [31:0] data;
    int          nbits;
    int          sel;

    tick(4);
    check("reset_duty", 32'(duty_cycle), 32'd0);
    check("reset_freq", frequency,       32'd0);
    check("reset_en",   32'(enable),     32'd0);
    check("reset_miso", 32'(miso),       32'd0);
    reset = 1'b0;
    tick(4);

    spi_frame(1'b1, 7'h01, 32'h0000_00FF, 40, 1'b0, rd);
    check("lit_freq_ff", frequency, 32'h0000_00FF);
    check("lit_duty_0",  32'(duty_cycle), 32'd0);
    check("lit_en_0",    32'(enable), 32'd0);

    spi_frame(1'b1, 7'h00, 32'hAB12_3456, 40, 1'b0, rd);
    check("lit_duty", 32'(duty_cycle), 32'h0012_3456);
    spi_frame(1'b0, 7'h00, 32'h0, 40, 1'b0, rd);
    check("lit_rd_duty", rd, 32'h0012_3456);

    spi_frame(1'b1, 7'h02, 32'h1, 40, 1'b0, rd);
    check("lit_en_1", 32'(enable), 32'd1);
    spi_frame(1'b1, 7'h03, 32'h0, 40, 1'b0, rd);
    spi_frame(1'b0, 7'h03, 32'h0, 40, 1'b0, rd);
    check("lit_rd_id", rd, 32'h5057_4D31);
    spi_frame(1'b0, 7'h7F, 32'h0, 40, 1'b0, rd);
    check("lit_rd_7f", rd, 32'h0);
    spi_frame(1'b0, 7'h01, 32'h0, 40, 1'b0, rd);
    check("lit_rd_freq", rd, 32'h0000_00FF);

    spi_frame(1'b1, 7'h01, 32'h1234_5678, 20, 1'b0, rd);
    check("lit_freq_kept", frequency, 32'h0000_00FF);
    spi_frame(1'b1, 7'h01, 32'h1234_5678, 40, 1'b0, rd);
    check("lit_freq_new", frequency, 32'h1234_5678);

    spi_frame(1'b1, 7'h02, 32'h0, 40, 1'b0, rd);
    check("lit_en_off", 32'(enable), 32'd0);
    spi_frame(1'b1, 7'h02, 32'h1, 48, 1'b0, rd);
    check("lit_en_48", 32'(enable), 32'd1);

    spi_frame(1'b1, 7'h01, 32'hDEAD_BEEF, 40, 1'b1, rd);
    check("lit_freq_after_rst", frequency, 32'd0);
    spi_frame(1'b1, 7'h01, 32'h00C0_FFEE, 40, 1'b0, rd);
    check("lit_freq_post_rst", frequency, 32'h00C0_FFEE);
    spi_frame(1'b0, 7'h01, 32'h0, 40, 1'b0, rd);
    check("lit_rd_post_rst", rd, 32'h00C0_FFEE);

    for (int k = 0; k < 30; k++) begin
      w    = 1'($urandom_range(1, 0));
      sel  = $urandom_range(5, 0);
      addr = (sel < 4) ? 7'(sel) : 7'($urandom_range(127, 0));
      data = $urandom;
      sel  = $urandom_range(5, 0);
      nbits = (sel == 0) ? $urandom_range(39, 1) : (sel == 1) ? $urandom_range(48, 41) : 40;
      exp = exp_read(addr);
      spi_frame(w, addr, data, nbits, 1'b0, rd);
      if (!w && nbits >= 40) check("rand_read", rd, exp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_pwm_regs.md
# spi_pwm_regs

SPI slave (mode 0) and control register file that sits directly upstream of the 3-channel PWM. It deserialises host frames and holds the `duty_cycle`, `frequency` and `enable` values that drive the PWM's same-named inputs. It also serves read-back of all registers. SPI pins are oversampled in the `clk` domain; no second clock exists.

## Interface
- `FRAME_BITS`, 40: bits per frame (8 command + 32 data).
- `ID_VALUE`, 32'h5057_4D31: read-only ID register contents.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock, asynchronous to `clk`.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `mosi`  in  1  SPI data in, asynchronous.
- `miso`  out  1  SPI data out; 0 when not shifting read data.
- `duty_cycle`  out  24  to PWM; channel nibbles at [23:20], [15:12], [7:4].
- `frequency`  out  32  to PWM prescaler terminal value.
- `enable`  out  1  to PWM enable.
- `frame_valid`  out  1  one-cycle pulse on every complete 40-bit frame.
- `frame_error`  out  1  one-cycle pulse when `cs_n` rises mid-frame.

## Operation
- `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchroniser. Rise and fall of synchronised `sclk` and `cs_n` are detected against a delayed copy.
- Frame format, MSB first on `mosi`:
  - cmd[7] is the W bit (1 = write, 0 = read).
  - cmd[6:0] is the address.
  - Then 32 data bits.
- Register map:
  - 0x00 DUTY: bits [23:0] valid, [31:24] read 0 and are ignored on write.
  - 0x01 FREQ: [31:0].
  - 0x02 CTRL: bit0 = enable, other bits read 0.
  - 0x03 ID: read-only `ID_VALUE`.
  - Any other address: writes ignored, reads return 0.
- FSM states: IDLE, CMD, DATA, WAIT.
  - IDLE → CMD on `cs_n` fall; the 6-bit bit counter clears.
  - CMD: shift `mosi` on each `sclk` rise. After the 8th bit, latch the command. If it is a read, load the 32-bit tx shift register with the addressed register value. Go to DATA.
  - DATA: shift on each `sclk` rise. On the 40th bit:
    - Pulse `frame_valid`.
    - If it is a write to a writable address, commit the data to that register in the same cycle.
    - Go to WAIT.
  - WAIT: further `sclk` edges are ignored until `cs_n` rises, then go to IDLE.
- `cs_n` rise in CMD or DATA: pulse `frame_error`, discard the frame (no register change), go to IDLE.
- `miso`:
  - During the DATA phase of a read, it presents tx[31] and shifts left on each synchronised `sclk` fall.
  - The first data bit is valid before the 9th `sclk` rise.
  - Otherwise `miso` = 0.
- Committed registers are only ever updated whole. The PWM never sees a partial value.
- `cs_n` fall while in WAIT/IDLE starts a new frame. Back-to-back frames need `cs_n` high for ≥ 4 `clk` cycles.

## Timing
- Reset values: `duty_cycle` = 0, `frequency` = 0, `enable` = 0, `miso` = 0, `frame_valid` = 0, `frame_error` = 0. FSM goes to IDLE and the counters clear.
- Reset asserted mid-frame aborts the frame silently; no `frame_error` pulse.
- Minimum `clk` per `sclk` half-period: 4 cycles, i.e. `sclk` ≤ `clk`/8.
- Pad-to-action latency: 3 `clk` edges. Registers update and `frame_valid` pulses on the 3rd `clk` rise after the 40th `sclk` rise is first sampled.
- `frame_error` pulses 3 `clk` rises after the `cs_n` rise is first sampled.
- All outputs are registered.

## Structure
- Package `spi_pwm_pkg` holds:
  - Address constants `ADDR_DUTY`, `ADDR_FREQ`, `ADDR_CTRL`, `ADDR_ID`.
  - `FRAME_BITS`, `CMD_BITS` = 8.
  - The FSM state enum.
- Sub-module `spi_sync_edge`: 2-FF synchroniser plus rise/fall detector. Instantiated for `sclk`, `cs_n` and `mosi` (edges unused for `mosi`).
- Top module: FSM, bit counter, rx/tx shift registers, register file.

## Test plan
- Write 0x01 ← 0x0000_00FF: `frequency` = 0x0000_00FF and `frame_valid` pulses once, 3 `clk` after the 40th `sclk` rise. Other registers are unchanged.
- Write 0x00 ← 0xAB12_3456: `duty_cycle` = 0x12_3456. Read 0x00 returns 0x0012_3456 on `miso`.
- Write 0x02 ← 1: `enable` = 1. Then write 0x03 ← 0: ID is unchanged, and read 0x03 returns 0x5057_4D31. Read 0x7F returns 0.
- Write 0x01 ← 0x1234_5678 with `cs_n` raised after 20 bits: `frame_error` pulses, `frequency` keeps its prior value, and the next full frame commits normally.
- 48 `sclk` pulses in one frame writing 0x02 ← 1: a single commit, one `frame_valid`, extra bits ignored.
- Assert `reset` during the DATA phase: all outputs are 0 immediately. The following frame is decoded correctly.
